load_store_unit: RTL

//  Sits between the execute stage and data_memory_unit. Accepts one load/store per handshake and drives the word-addressed memory port.
//  Sub-word stores (SB/SH) are done as read-modify-write. Loads return sign/zero-extended data.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_align.sv | 54 +++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lsu_pkg                                                        |
// | Purpose  : Shared definitions for the load/store unit: RV32 funct3        |
// |            access-size encodings and the FSM state encoding.             |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WRITE  = 2'd2,
      ST_RESP   = 2'd3
   } lsu_state_t;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lsu_align                                                      |
// | Purpose  : Combinational lane steering for the load/store unit.           |
// |            Extracts and extends the addressed byte/half of a load word,   |
// |            and merges store data into the current memory word.           |
// | Ports    : funct3     - access size/sign (RV32 encoding)                  |
// |            addr_lo    - byte offset within the word                      |
// |            rdata      - word read from memory                            |
// |            wdata      - right-justified store data                       |
// |            load_data  - extended load result                             |
// |            store_word - word to write back to memory                     |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = rdata[{addr_lo, 3'b000} +: 8];
      // Halves are 2-aligned by the time they reach here, so addr_lo[1] picks the lane.
      w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    load_data = {{16{w_half[15]}}, w_half};
         F3_BU:   load_data = {24'h0, w_byte};
         F3_HU:   load_data = {16'h0, w_half};
         default: load_data = rdata;
      endcase

      store_word = rdata;
      case (funct3)
         F3_B: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         F3_H: begin
            if (addr_lo[1]) store_word[31:16] = wdata[15:0];
            else            store_word[15:0]  = wdata[15:0];
         end
         default: store_word = wdata;
      endcase
   end

endmodule : lsu_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : load_store_unit                                                |
// | Purpose  : Bridges execute-stage load/store requests to a word-addressed  |
// |            data memory. Sub-word stores use read-modify-write; loads are |
// |            sign/zero-extended. Misaligned, out-of-range and illegal-size |
// |            requests are flagged without touching memory.                 |
// | Ports    : req_*  - request handshake (valid/ready) with we/funct3/addr/ |
// |                     wdata                                                |
// |            resp_* - response handshake with rdata and error flags        |
// |            mem_*  - data_memory_unit port (combinational read)           |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS  = 64,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_misaligned,
   output logic                  resp_fault,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_write_data,
   input  logic [31:0]           mem_read_data
);

   localparam logic [ADDR_WIDTH-3:0] C_MEM_WORDS = (ADDR_WIDTH-2)'(MEM_WORDS);

   lsu_state_t              r_state;
   lsu_state_t              w_state_next;
   logic                    r_we;
   logic [2:0]              r_funct3;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [31:0]             r_wdata;
   logic [31:0]             r_rdata;
   logic [31:0]             r_merged;
   logic                    r_misaligned;
   logic                    r_fault;

   logic                    w_accept;
   logic                    w_misaligned;
   logic                    w_bad_f3;
   logic                    w_fault;
   logic                    w_sw;
   logic [31:0]             w_load_data;
   logic [31:0]             w_store_word;

   // Request checks act on the live request so the error path can reach RESP
   // one cycle after the accept edge.
   always_comb begin
      w_misaligned = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                     ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
      case (req_funct3)
         F3_B, F3_H, F3_W: w_bad_f3 = 1'b0;
         F3_BU, F3_HU:     w_bad_f3 = req_we;   // unsigned sizes are load-only
         default:          w_bad_f3 = 1'b1;
      endcase
      // Misaligned wins so the two flags are mutually exclusive.
      w_fault = !w_misaligned &&
                (w_bad_f3 || (req_addr[ADDR_WIDTH-1:2] >= C_MEM_WORDS));
   end

   assign w_accept = req_valid && req_ready;
   assign w_sw     = r_we && (r_funct3 == F3_W);

   lsu_align u_align (
      .funct3     (r_funct3),
      .addr_lo    (r_addr[1:0]),
      .rdata      (mem_read_data),
      .wdata      (r_wdata),
      .load_data  (w_load_data),
      .store_word (w_store_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_misaligned || w_fault) w_state_next = ST_RESP;
               else                         w_state_next = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // Sub-word stores need one more cycle to write the merged word.
            if (r_we && !w_sw) w_state_next = ST_WRITE;
            else               w_state_next = ST_RESP;
         end
         ST_WRITE: w_state_next = ST_RESP;
         ST_RESP: begin
            if (resp_ready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we         <= 1'b0;
         r_funct3     <= 3'b000;
         r_addr       <= '0;
         r_wdata      <= 32'h0;
         r_rdata      <= 32'h0;
         r_merged     <= 32'h0;
         r_misaligned <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_we         <= req_we;
                  r_funct3     <= req_funct3;
                  r_addr       <= req_addr;
                  r_wdata      <= req_wdata;
                  r_rdata      <= 32'h0;
                  r_misaligned <= w_misaligned;
                  r_fault      <= w_fault;
               end
            end
            ST_ACCESS: begin
               if (!r_we) r_rdata <= w_load_data;
               r_merged <= w_store_word;
            end
            default: ;
         endcase
      end
   end

   assign req_ready        = (r_state == ST_IDLE);
   assign resp_valid       = (r_state == ST_RESP);
   assign resp_rdata       = r_rdata;
   assign resp_misaligned  = r_misaligned;
   assign resp_fault       = r_fault;
   assign mem_address      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
   assign mem_write_enable = ((r_state == ST_ACCESS) && w_sw) || (r_state == ST_WRITE);
   assign mem_write_data   = (r_state == ST_WRITE) ? r_merged : w_store_word;

endmodule : load_store_unit
`default_nettype wire
